load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, 32, data and address width.
REQ-002 Port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 Port data_req_i  in  1  memory access requested by the instruction in execute.
REQ-005 Port data_wr_i  in  1  1=store, 0=load.
REQ-006 Port data_byte_i  in  2  access size: BYTE, HALF_WORD, WORD.
REQ-007 Port zero_extnd_i  in  1  load result zero-extended (LBU/LHU); 0 means sign-extend.
REQ-008 Port addr_i  in  XLEN  effective byte address (ALU result).
REQ-009 Port wdata_i  in  XLEN  store data (rs2).
REQ-010 Port lsu_stall_o  out  1  hold the pipeline.
REQ-011 Port rdata_o  out  XLEN  aligned, extended load data.
REQ-012 Port rdata_valid_o  out  1  access completed.
REQ-013 Port misaligned_o  out  1  access rejected as misaligned.
REQ-014 Port mem_req_o  out  1  memory request valid.
REQ-015 Port mem_gnt_i  in  1  memory accepts request.
REQ-016 Port mem_addr_o  out  XLEN  word address, bits [1:0] forced to 0.
REQ-017 Port mem_we_o  out  1  write enable.
REQ-018 Port mem_be_o  out  4  byte enables.
REQ-019 Port mem_wdata_o  out  XLEN  lane-replicated store data.
REQ-020 Port mem_rvalid_i  in  1  response/acknowledge, one per granted request.
REQ-021 Port mem_rdata_i  in  XLEN  read data, valid with mem_rvalid_i.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-023 IDLE with data_req_i=1 and an aligned access: latch address, size, write flag, extension flag and data; go to REQ.
REQ-024 IDLE with data_req_i=1 and a misaligned access (HALF_WORD with addr[0]=1; WORD with addr[1:0]!=0): go to DONE with the misaligned flag set; issue no memory request.
REQ-025 REQ: mem_req_o=1 with registered address, we, be and wdata held stable; on mem_gnt_i=1 go to WAIT.
REQ-026 WAIT: on mem_rvalid_i=1, capture the response (loads) and go to DONE; stores also wait for mem_rvalid_i.
REQ-027 DONE: drive rdata_valid_o=1, or misaligned_o=1 if flagged, for exactly one cycle; ignore data_req_i; return to IDLE.
REQ-028 lsu_stall_o = (IDLE and data_req_i) or REQ or WAIT; it is 0 in DONE.
REQ-029 Minimum aligned latency: request accepted in cycle 0, mem_req_o in cycle 1, DONE in cycle 3 with zero-wait gnt/rvalid.
REQ-030 Byte enables: BYTE gives 4'b0001<<addr[1:0]; HALF_WORD gives 4'b0011<<{addr[1],1'b0}; WORD gives 4'b1111.
REQ-031 Store data: BYTE gives {4{wdata[7:0]}}; HALF_WORD gives {2{wdata[15:0]}}; WORD is passed through.
REQ-032 Load data: select the lane by the latched addr[1:0]; zero- or sign-extend to XLEN per zero_extnd; rdata_o is held until the next DONE.
REQ-033 data_byte_i=2'b11 SHALL be treated as WORD.
REQ-034 mem_gnt_i outside REQ and mem_rvalid_i outside WAIT SHALL be ignored; mem_rvalid_i in the grant cycle is not accepted.
REQ-035 rdata_o SHALL be 0 after a store or a misaligned access.

Reset
REQ-036 Asserting rst_ni low SHALL force IDLE immediately and clear every output to 0, including in the middle of REQ or WAIT.
REQ-037 A memory response arriving after reset SHALL be discarded.

Structure
REQ-038 The BYTE/HALF_WORD/WORD encodings and the lsu_state_t enum SHALL live in cpu_consts.
REQ-039 Load lane extraction and extension SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-040 LW at 0x100 with mem_rdata=0xDEADBEEF and zero-wait memory -> mem_addr_o=0x100, be=1111, rdata_o=0xDEADBEEF with rdata_valid_o in cycle 3.
REQ-041 LB at 0x103 with rdata=0x80FF_FF00, and LBU at the same address -> rdata_o=0xFFFFFF80 and 0x00000080 respectively.
REQ-042 SH at 0x102 with wdata=0x1234ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1.
REQ-043 LH at 0x101 -> no mem_req_o, misaligned_o pulse in cycle 1, lsu_stall_o high in cycle 0 only.
REQ-044 mem_gnt_i delayed 3 cycles and rvalid delayed 2 more -> mem outputs stable throughout, stall held, a single rdata_valid_o pulse.
REQ-045 rst_ni asserted during WAIT, then a late mem_rvalid_i -> all outputs 0 and no rdata_valid_o.

Source files
------------

// File: rtl/cpu_consts.sv
// Shared constants for the load/store unit.
//   BYTE / HALF_WORD / WORD : access-size encodings carried on data_byte_i
//                             (2'b11 is treated as WORD)
//   lsu_state_t             : access FSM states
//   is_misaligned()         : alignment check for a size/offset pair
//   byte_enable()           : 4-lane byte enables for a size/offset pair
package cpu_consts;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // Anything that is neither BYTE nor HALF_WORD behaves as a full word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    case (size)
      BYTE:      return 1'b0;
      HALF_WORD: return offset[0];
      default:   return (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] offset);
    case (size)
      BYTE:      return 4'b0001 << offset;
      HALF_WORD: return 4'b0011 << {offset[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner.
//   rdata      : raw word returned by memory
//   offset     : byte offset of the access within the word
//   size       : BYTE / HALF_WORD / WORD (2'b11 treated as WORD)
//   zero_extnd : 1 = zero-extend, 0 = sign-extend the selected lane
//   data       : lane-selected, extended load result
module lsu_load_align
  import cpu_consts::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            zero_extnd,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        fill;

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    fill      = 1'b0;
    data      = rdata;

    case (offset)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      BYTE: begin
        fill = ~zero_extnd & byte_lane[7];
        data = {{(XLEN-8){fill}}, byte_lane};
      end
      HALF_WORD: begin
        fill = ~zero_extnd & half_lane[15];
        data = {{(XLEN-16){fill}}, half_lane};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory access into a single
// request/grant/response transaction on a word-addressed memory port.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   data_req_i ... wdata_i: access request from the pipeline
//   lsu_stall_o           : holds the pipeline while the access is in flight
//   rdata_o/_valid_o      : aligned load result and completion pulse
//   misaligned_o          : completion pulse for a rejected misaligned access
//   mem_*                 : memory request channel (req/gnt) and response (rvalid/rdata)
module load_store_unit
  import cpu_consts::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            data_req_i,
  input  logic            data_wr_i,
  input  logic [1:0]      data_byte_i,
  input  logic            zero_extnd_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            lsu_stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
  output logic            misaligned_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic            wr_q;
  logic            zext_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            mis_q;
  logic [XLEN-1:0] rdata_q;

  logic            accept;
  logic            mis_now;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] load_data;

  assign accept  = (state_q == IDLE) && data_req_i;
  assign mis_now = is_misaligned(data_byte_i, addr_i[1:0]);

  // Store data is replicated across every lane so memory can pick it up
  // with the byte enables alone.
  always_comb begin
    case (data_byte_i)
      BYTE:      wdata_rep = {(XLEN/8){wdata_i[7:0]}};
      HALF_WORD: wdata_rep = {(XLEN/16){wdata_i[15:0]}};
      default:   wdata_rep = wdata_i;
    endcase
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata      (mem_rdata_i),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .zero_extnd (zext_q),
    .data       (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Misaligned accesses skip the memory port entirely and report in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_req_i) state_d = mis_now ? DONE : REQ;
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // rdata_q only changes on the way into DONE, so the last result stays
  // visible until the next access completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      size_q  <= WORD;
      wr_q    <= 1'b0;
      zext_q  <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      mis_q <= mis_now;
      if (mis_now) begin
        rdata_q <= '0;
      end else begin
        addr_q  <= addr_i;
        size_q  <= data_byte_i;
        wr_q    <= data_wr_i;
        zext_q  <= zero_extnd_i;
        be_q    <= byte_enable(data_byte_i, addr_i[1:0]);
        wdata_q <= wdata_rep;
      end
    end else if ((state_q == WAIT) && mem_rvalid_i) begin
      rdata_q <= wr_q ? '0 : load_data;
    end
  end

  assign lsu_stall_o   = accept || (state_q == REQ) || (state_q == WAIT);
  assign rdata_valid_o = (state_q == DONE) && !mis_q;
  assign misaligned_o  = (state_q == DONE) && mis_q;
  assign rdata_o       = rdata_q;

  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = mem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_we_o    = mem_req_o && wr_q;
  assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: zero-wait loads and stores,
// byte/half lane handling, misaligned rejection, stretched handshakes and
// reset in the middle of an access.
module tb_load_store_unit;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_wr_i;
  logic [1:0]  data_byte_i;
  logic        zero_extnd_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        lsu_stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_wr_i     (data_wr_i),
    .data_byte_i   (data_byte_i),
    .zero_extnd_i  (zero_extnd_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .lsu_stall_o   (lsu_stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misaligned_o  (misaligned_o),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled away from the rising edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] size,
                               input logic zext, input logic [31:0] addr,
                               input logic [31:0] wdata);
    data_req_i   = req;
    data_wr_i    = wr;
    data_byte_i  = size;
    zero_extnd_i = zext;
    addr_i       = addr;
    wdata_i      = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One access against a memory that grants and responds immediately.
  task automatic zeroWaitAccess(input string tag, input logic wr, input logic [1:0] size,
                                input logic zext, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    step();
    applyStimulus(1'b1, wr, size, zext, addr, wdata);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    #1;
    checkOutput({tag, " c0 stall"}, {31'd0, lsu_stall_o}, 32'd1);
    checkOutput({tag, " c0 req"}, {31'd0, mem_req_o}, 32'd0);
    step(); #1;
    checkOutput({tag, " c1 req"}, {31'd0, mem_req_o}, 32'd1);
    checkOutput({tag, " c1 addr"}, mem_addr_o, exp_addr);
    checkOutput({tag, " c1 be"}, {28'd0, mem_be_o}, {28'd0, exp_be});
    checkOutput({tag, " c1 we"}, {31'd0, mem_we_o}, {31'd0, wr});
    checkOutput({tag, " c1 wdata"}, mem_wdata_o, exp_wdata);
    step(); #1;
    checkOutput({tag, " c2 stall"}, {31'd0, lsu_stall_o}, 32'd1);
    checkOutput({tag, " c2 valid"}, {31'd0, rdata_valid_o}, 32'd0);
    step();
    data_req_i = 1'b0;
    #1;
    checkOutput({tag, " c3 valid"}, {31'd0, rdata_valid_o}, 32'd1);
    checkOutput({tag, " c3 rdata"}, rdata_o, exp_rdata);
    checkOutput({tag, " c3 stall"}, {31'd0, lsu_stall_o}, 32'd0);
    step(); #1;
    checkOutput({tag, " c4 valid"}, {31'd0, rdata_valid_o}, 32'd0);
    checkOutput({tag, " c4 rdata held"}, rdata_o, exp_rdata);
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    checkOutput("reset stall", {31'd0, lsu_stall_o}, 32'd0);
    checkOutput("reset req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("reset rdata", rdata_o, 32'd0);
    checkOutput("reset valid", {31'd0, rdata_valid_o}, 32'd0);
    step();
    rst_ni = 1'b1;

    zeroWaitAccess("LW", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
                   32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    zeroWaitAccess("LB", 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FFFF00,
                   32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    zeroWaitAccess("LBU", 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FFFF00,
                   32'h100, 4'b1000, 32'h0, 32'h00000080);
    zeroWaitAccess("LH", 1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, 32'h9ABC1234,
                   32'h200, 4'b1100, 32'h0, 32'hFFFF9ABC);

    // Misaligned half-word: rejected without touching memory.
    step();
    applyStimulus(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0);
    #1;
    checkOutput("mis c0 stall", {31'd0, lsu_stall_o}, 32'd1);
    step();
    data_req_i = 1'b0;
    #1;
    checkOutput("mis c1 flag", {31'd0, misaligned_o}, 32'd1);
    checkOutput("mis c1 req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("mis c1 stall", {31'd0, lsu_stall_o}, 32'd0);
    checkOutput("mis c1 valid", {31'd0, rdata_valid_o}, 32'd0);
    checkOutput("mis c1 rdata", rdata_o, 32'd0);
    step(); #1;
    checkOutput("mis c2 flag", {31'd0, misaligned_o}, 32'd0);
    checkOutput("mis c2 req", {31'd0, mem_req_o}, 32'd0);

    zeroWaitAccess("SH", 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234ABCD, 32'h55555555,
                   32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
    zeroWaitAccess("SB", 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000A5, 32'h55555555,
                   32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
    zeroWaitAccess("LHU", 1'b0, SZ_HALF, 1'b1, 32'h300, 32'h0, 32'h1234F00D,
                   32'h300, 4'b0011, 32'h0, 32'h0000F00D);

    // Stretched handshake, size 2'b11 behaves as a word access.
    step();
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h204, 32'h0);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
      end
      #1;
      checkOutput($sformatf("slow c%0d req", c), {31'd0, mem_req_o}, 32'd1);
      checkOutput($sformatf("slow c%0d addr", c), mem_addr_o, 32'h204);
      checkOutput($sformatf("slow c%0d be", c), {28'd0, mem_be_o}, 32'hF);
      checkOutput($sformatf("slow c%0d stall", c), {31'd0, lsu_stall_o}, 32'd1);
    end
    for (int c = 4; c <= 6; c++) begin
      step();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = (c == 6);
      mem_rdata_i = (c == 6) ? 32'h0BADF00D : 32'h22222222;
      #1;
      checkOutput($sformatf("slow c%0d stall", c), {31'd0, lsu_stall_o}, 32'd1);
      checkOutput($sformatf("slow c%0d req", c), {31'd0, mem_req_o}, 32'd0);
      checkOutput($sformatf("slow c%0d valid", c), {31'd0, rdata_valid_o}, 32'd0);
    end
    step();
    mem_rvalid_i = 1'b0; data_req_i = 1'b0;
    #1;
    checkOutput("slow c7 valid", {31'd0, rdata_valid_o}, 32'd1);
    checkOutput("slow c7 rdata", rdata_o, 32'h0BADF00D);
    step(); #1;
    checkOutput("slow c8 valid", {31'd0, rdata_valid_o}, 32'd0);

    // Reset while waiting for the response, then a stale response.
    step();
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    step();
    step();
    data_req_i = 1'b0;
    #1;
    checkOutput("rst wait stall", {31'd0, lsu_stall_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst async stall", {31'd0, lsu_stall_o}, 32'd0);
    checkOutput("rst async req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst async addr", mem_addr_o, 32'd0);
    checkOutput("rst async be", {28'd0, mem_be_o}, 32'd0);
    checkOutput("rst async rdata", rdata_o, 32'd0);
    checkOutput("rst async valid", {31'd0, rdata_valid_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEBABE;
    #1;
    checkOutput("late rsp stall", {31'd0, lsu_stall_o}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      mem_rvalid_i = 1'b0;
      #1;
      checkOutput($sformatf("late rsp valid %0d", c), {31'd0, rdata_valid_o}, 32'd0);
      checkOutput($sformatf("late rsp rdata %0d", c), rdata_o, 32'd0);
      checkOutput($sformatf("late rsp req %0d", c), {31'd0, mem_req_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
